// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// One combinational restoring-division stage: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_div,
  output logic [VW-1:0] o_rem,
  output logic          o_qbit
);

  logic [VW:0] w_trial;
  logic [VW:0] w_div_ext;

  assign w_trial   = {i_rem, i_bit};
  assign w_div_ext = {1'b0, i_div};

  // The incoming remainder is below the divisor, so trial-divisor always fits in VW bits.
  always_comb begin
    o_qbit = 1'b0;
    o_rem  = i_rem;
    if (w_trial >= w_div_ext) begin
      o_qbit = 1'b1;
      o_rem  = VW'(w_trial - w_div_ext);
    end else begin
      o_rem  = w_trial[VW-1:0];
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, start/busy/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  seq_restoring_divider_if.slave  bus
);

  localparam int CW = cnt_w(DW);

  div_state_t    r_state;
  div_state_t    w_next;

  // Partial remainder top bit is provably zero after every step, so only VW bits are kept.
  logic [VW-1:0] r_rem;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_remo;
  logic          r_dbz;

  logic          w_accept;
  logic          w_div_zero;
  logic          w_last;
  logic [VW-1:0] w_rem;
  logic          w_qbit;

  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
  assign w_div_zero = (bus.divisor == '0);
  assign w_last     = (r_cnt == '0);

  div_step #(
    .VW(VW)
  ) u_step (
    .i_rem (r_rem),
    .i_bit (r_q[DW-1]),
    .i_div (r_div),
    .o_rem (w_rem),
    .o_qbit(w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_div_zero ? DONE : RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (w_accept) w_next = w_div_zero ? DONE : RUN;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_div <= bus.divisor;
      if (w_div_zero) begin
        r_quot <= '1;
        r_remo <= '0;
        r_dbz  <= 1'b1;
      end else begin
        r_rem <= '0;
        r_q   <= bus.dividend;
        r_cnt <= CW'(DW - 1);
        r_dbz <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem;
      r_q   <= {r_q[DW-2:0], w_qbit};
      // The final step's result goes straight to the output registers.
      if (w_last) begin
        r_quot <= {r_q[DW-2:0], w_qbit};
        r_remo <= w_rem;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dbz;

endmodule
